// File: rtl/pipeline_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl_pkg
// Shared types and constants for the pipeline stall/flush scheduler.
//   ctrl_state_t : scheduler FSM encoding (RUN / MEM_WAIT / HALT)
//   REG_X0       : architectural zero register index
//   is_load_use  : load-use hazard detector between EX and DE
// -----------------------------------------------------------------------------
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } ctrl_state_t;

    localparam logic [4:0] REG_X0 = 5'd0;

    // x0 is hard-wired to zero, so a load targeting it never creates a hazard.
    function automatic logic is_load_use(
        input logic       dmrd_ex,
        input logic [4:0] rd_ex,
        input logic [4:0] rs1_de,
        input logic [4:0] rs2_de
    );
        return dmrd_ex && (rd_ex != REG_X0) &&
               ((rd_ex == rs1_de) || (rd_ex == rs2_de));
    endfunction

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Saturating up-counter used for the scheduler performance counters.
//   clk   : clock
//   rst   : synchronous active-high clear (wins over inc)
//   inc   : count one event this cycle
//   count : current value, sticks at all-ones
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;

    // NOTE: sequential state is written with <= so every flop samples the
    // pre-edge values, independent of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (inc && (count_q != {W{1'b1}})) begin
            count_q <= count_q + W'(1);
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl
// Stall/flush scheduler for the five-stage pipeline. Decides each cycle which
// pipeline registers load, hold or take a bubble; detects data-memory
// timeouts and counts stall cycles and taken-branch flushes.
//   clk, rst                 : clock, synchronous active-high reset
//   rs1_de, rs2_de           : source registers of the instruction in DE
//   rd_ex, DMRd_ex           : destination / is-load of the instruction in EX
//   br_taken_ex              : branch/jump in EX resolved taken
//   dm_req_me, dm_ready      : data-memory access in ME and its completion
//   en_fe..en_wb             : pipeline-register / PC load enables
//   clr_de, clr_ex           : load a bubble into DE / EX at the next edge
//   mem_err                  : sticky data-memory timeout flag
//   state_o                  : current FSM state
//   stall_cnt, flush_cnt     : saturating performance counters
// -----------------------------------------------------------------------------
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs1_de,
    input  logic [4:0]       rs2_de,
    input  logic [4:0]       rd_ex,
    input  logic             DMRd_ex,
    input  logic             br_taken_ex,
    input  logic             dm_req_me,
    input  logic             dm_ready,
    output logic             en_fe,
    output logic             en_de,
    output logic             en_ex,
    output logic             en_me,
    output logic             en_wb,
    output logic             clr_de,
    output logic             clr_ex,
    output logic             mem_err,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int WAIT_W = 8;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    ctrl_state_t       state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              mem_err_q, mem_err_d;

    logic load_use;
    logic mem_stall;
    logic service;     // evaluate branch / hazard / normal rules this cycle
    logic flush_inc;
    logic stall_inc;

    assign load_use  = is_load_use(DMRd_ex, rd_ex, rs1_de, rs2_de);
    // Inside MEM_WAIT a dropped request is treated as completion, so
    // mem_stall alone decides whether the freeze continues.
    assign mem_stall = dm_req_me & ~dm_ready;

    // NOTE: memories are not involved here; every register below is cleared
    // by rst because the FSM must restart in RUN from any state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
            mem_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            mem_err_q  <= mem_err_d;
        end
    end

    // NOTE: every output of this block gets a default first so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        en_fe      = 1'b1;
        en_de      = 1'b1;
        en_ex      = 1'b1;
        en_me      = 1'b1;
        en_wb      = 1'b1;
        clr_de     = 1'b0;
        clr_ex     = 1'b0;
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        mem_err_d  = mem_err_q;
        service    = 1'b0;
        flush_inc  = 1'b0;

        if (rst) begin
            // Pipeline flushes to bubbles while reset is held.
            clr_de = 1'b1;
            clr_ex = 1'b1;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (mem_stall) begin
                        {en_fe, en_de, en_ex, en_me, en_wb} = '0;
                        state_d    = MEM_WAIT;
                        wait_cnt_d = WAIT_W'(1);
                    end else begin
                        service = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    if (mem_stall) begin
                        {en_fe, en_de, en_ex, en_me, en_wb} = '0;
                        wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                        if (wait_cnt_q == WAIT_LAST) begin
                            state_d   = HALT;
                            mem_err_d = 1'b1;
                        end
                    end else begin
                        // Completion wins even in the final allowed cycle.
                        service    = 1'b1;
                        state_d    = RUN;
                        wait_cnt_d = '0;
                    end
                end
                HALT: begin
                    {en_fe, en_de, en_ex, en_me, en_wb} = '0;
                end
                default: begin
                    state_d = RUN;
                end
            endcase

            if (service) begin
                if (br_taken_ex) begin
                    // A hazard alongside a taken branch is on the wrong path.
                    clr_de    = 1'b1;
                    clr_ex    = 1'b1;
                    flush_inc = 1'b1;
                end else if (load_use) begin
                    en_fe  = 1'b0;
                    en_de  = 1'b0;
                    clr_ex = 1'b1;
                end
            end
        end
    end

    assign stall_inc = ~rst & ~(en_fe & en_de & en_ex & en_me & en_wb);
    assign mem_err   = mem_err_q;
    assign state_o   = state_q;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush_inc),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_ctrl
// Self-checking bench for pipeline_ctrl (MEM_TIMEOUT = 4, CNT_W = 3).
// Single-cycle decisions come from a vector table; multi-cycle behaviour
// (memory wait, timeout, saturation, reset) uses hand-written sequences.
// Expected outputs are queued when inputs are driven and compared when the
// outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_pipeline_ctrl;
    import pipeline_ctrl_pkg::*;

    localparam int TO = 4;
    localparam int CW = 3;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       dmrd;
        logic       br;
        logic       req;
        logic       rdy;
    } in_t;

    typedef struct packed {
        logic [4:0] en;      // {fe, de, ex, me, wb}
        logic [1:0] clr;     // {clr_de, clr_ex}
        logic [1:0] st;
        logic       err;
    } exp_t;

    typedef struct {
        string      name;
        in_t        in;
        exp_t       ex;
        int         stall;   // stall_cnt after the edge
        int         flush;   // flush_cnt after the edge
        logic [1:0] nst;     // state after the edge
    } vec_t;

    localparam logic [4:0] EN_ALL  = 5'b11111;
    localparam logic [4:0] EN_NONE = 5'b00000;
    localparam logic [4:0] EN_LU   = 5'b00111;

    logic          clk = 1'b0;
    logic          rst;
    logic [4:0]    rs1_de, rs2_de, rd_ex;
    logic          DMRd_ex, br_taken_ex, dm_req_me, dm_ready;
    logic          en_fe, en_de, en_ex, en_me, en_wb;
    logic          clr_de, clr_ex, mem_err;
    logic [1:0]    state_o;
    logic [CW-1:0] stall_cnt, flush_cnt;
    logic [4:0]    en_vec;

    int   total = 0;
    int   bad   = 0;
    exp_t sb_q[$];
    vec_t vecs[12];

    always #5 clk = ~clk;

    assign en_vec = {en_fe, en_de, en_ex, en_me, en_wb};

    pipeline_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .rs1_de      (rs1_de),
        .rs2_de      (rs2_de),
        .rd_ex       (rd_ex),
        .DMRd_ex     (DMRd_ex),
        .br_taken_ex (br_taken_ex),
        .dm_req_me   (dm_req_me),
        .dm_ready    (dm_ready),
        .en_fe       (en_fe),
        .en_de       (en_de),
        .en_ex       (en_ex),
        .en_me       (en_me),
        .en_wb       (en_wb),
        .clr_de      (clr_de),
        .clr_ex      (clr_ex),
        .mem_err     (mem_err),
        .state_o     (state_o),
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt)
    );

    function automatic in_t mk_in(input logic [4:0] rs1, input logic [4:0] rs2,
                                  input logic [4:0] rd, input logic dmrd,
                                  input logic br, input logic req, input logic rdy);
        in_t i;
        i.rs1 = rs1; i.rs2 = rs2; i.rd = rd; i.dmrd = dmrd;
        i.br = br; i.req = req; i.rdy = rdy;
        return i;
    endfunction

    function automatic exp_t mk_ex(input logic [4:0] en, input logic [1:0] clr,
                                   input logic [1:0] st, input logic err);
        exp_t e;
        e.en = en; e.clr = clr; e.st = st; e.err = err;
        return e;
    endfunction

    function automatic vec_t mk_vec(input string name, input in_t in, input exp_t ex,
                                    input int stall, input int flush, input logic [1:0] nst);
        vec_t v;
        v.name = name; v.in = in; v.ex = ex;
        v.stall = stall; v.flush = flush; v.nst = nst;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input in_t i);
        rs1_de      = i.rs1;
        rs2_de      = i.rs2;
        rd_ex       = i.rd;
        DMRd_ex     = i.dmrd;
        br_taken_ex = i.br;
        dm_req_me   = i.req;
        dm_ready    = i.rdy;
    endtask

    // Drive one cycle of inputs, compare the Mealy outputs mid-cycle, then
    // let the edge happen.
    task automatic step(input string name, input in_t i, input exp_t e);
        exp_t x;
        drive(i);
        sb_q.push_back(e);
        @(negedge clk);
        x = sb_q.pop_front();
        check({name, ".en"},  32'(en_vec),           32'(x.en));
        check({name, ".clr"}, 32'({clr_de, clr_ex}), 32'(x.clr));
        check({name, ".st"},  32'(state_o),          32'(x.st));
        check({name, ".err"}, 32'(mem_err),          32'(x.err));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input in_t i);
        drive(i);
        rst = 1'b1;
        @(negedge clk);
        check("rst.en",  32'(en_vec),           32'(EN_ALL));
        check("rst.clr", 32'({clr_de, clr_ex}), 32'(2'b11));
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic check_regs(input string name, input logic [1:0] st, input logic err,
                              input int stall, input int flush);
        check({name, ".state"}, 32'(state_o),   32'(st));
        check({name, ".err"},   32'(mem_err),   32'(err));
        check({name, ".stall"}, 32'(stall_cnt), 32'(stall));
        check({name, ".flush"}, 32'(flush_cnt), 32'(flush));
    endtask

    initial begin
        in_t idle, lu, ms, rdy, br;
        idle = mk_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        lu   = mk_in(5'd1, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        ms   = mk_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        rdy  = mk_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        br   = mk_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);

        vecs[0]  = mk_vec("idle",     idle, mk_ex(EN_ALL, 2'b00, RUN, 1'b0), 0, 0, RUN);
        vecs[1]  = mk_vec("lu_rs2",   lu,   mk_ex(EN_LU,  2'b01, RUN, 1'b0), 1, 0, RUN);
        vecs[2]  = mk_vec("lu_rs1",   mk_in(5'd7, 5'd3, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0),
                          mk_ex(EN_LU, 2'b01, RUN, 1'b0), 1, 0, RUN);
        vecs[3]  = mk_vec("x0",       mk_in(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0),
                          mk_ex(EN_ALL, 2'b00, RUN, 1'b0), 0, 0, RUN);
        vecs[4]  = mk_vec("no_load",  mk_in(5'd1, 5'd5, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0),
                          mk_ex(EN_ALL, 2'b00, RUN, 1'b0), 0, 0, RUN);
        vecs[5]  = mk_vec("rd_miss",  mk_in(5'd4, 5'd6, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0),
                          mk_ex(EN_ALL, 2'b00, RUN, 1'b0), 0, 0, RUN);
        vecs[6]  = mk_vec("branch",   br,   mk_ex(EN_ALL, 2'b11, RUN, 1'b0), 0, 1, RUN);
        vecs[7]  = mk_vec("br_lu",    mk_in(5'd1, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0),
                          mk_ex(EN_ALL, 2'b11, RUN, 1'b0), 0, 1, RUN);
        vecs[8]  = mk_vec("mstall",   ms,   mk_ex(EN_NONE, 2'b00, RUN, 1'b0), 1, 0, MEM_WAIT);
        vecs[9]  = mk_vec("mem_ok",   rdy,  mk_ex(EN_ALL, 2'b00, RUN, 1'b0), 0, 0, RUN);
        vecs[10] = mk_vec("ms_br",    mk_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0),
                          mk_ex(EN_NONE, 2'b00, RUN, 1'b0), 1, 0, MEM_WAIT);
        vecs[11] = mk_vec("rdy_noreq", mk_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0),
                          mk_ex(EN_ALL, 2'b00, RUN, 1'b0), 0, 0, RUN);

        rst = 1'b1;
        drive(idle);
        @(posedge clk);
        #1;
        do_reset(idle);
        check_regs("reset", RUN, 1'b0, 0, 0);

        // Single-cycle decisions from RUN.
        for (int k = 0; k < 12; k++) begin
            do_reset(idle);
            step(vecs[k].name, vecs[k].in, vecs[k].ex);
            check({vecs[k].name, ".stall"}, 32'(stall_cnt), 32'(vecs[k].stall));
            check({vecs[k].name, ".flush"}, 32'(flush_cnt), 32'(vecs[k].flush));
            check({vecs[k].name, ".nst"},   32'(state_o),   32'(vecs[k].nst));
        end

        // Load-use costs one bubble, then the pipeline runs again.
        do_reset(idle);
        step("lu1", lu, mk_ex(EN_LU, 2'b01, RUN, 1'b0));
        step("lu2", idle, mk_ex(EN_ALL, 2'b00, RUN, 1'b0));
        check_regs("lu_end", RUN, 1'b0, 1, 0);

        // Memory wait: three stalled cycles, ready in the third MEM_WAIT cycle.
        do_reset(idle);
        step("mw1", ms,  mk_ex(EN_NONE, 2'b00, RUN,      1'b0));
        step("mw2", ms,  mk_ex(EN_NONE, 2'b00, MEM_WAIT, 1'b0));
        step("mw3", ms,  mk_ex(EN_NONE, 2'b00, MEM_WAIT, 1'b0));
        step("mw4", rdy, mk_ex(EN_ALL,  2'b00, MEM_WAIT, 1'b0));
        check_regs("mw_end", RUN, 1'b0, 3, 0);
        step("mw5", idle, mk_ex(EN_ALL, 2'b00, RUN, 1'b0));

        // A branch held during the wait is serviced on completion.
        do_reset(idle);
        step("hb1", mk_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0),
             mk_ex(EN_NONE, 2'b00, RUN, 1'b0));
        step("hb2", mk_in(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1),
             mk_ex(EN_ALL, 2'b11, MEM_WAIT, 1'b0));
        check_regs("hb_end", RUN, 1'b0, 1, 1);

        // A hazard held during the wait is serviced on completion.
        do_reset(idle);
        step("hl1", mk_in(5'd1, 5'd5, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0),
             mk_ex(EN_NONE, 2'b00, RUN, 1'b0));
        step("hl2", mk_in(5'd1, 5'd5, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1),
             mk_ex(EN_LU, 2'b01, MEM_WAIT, 1'b0));
        check_regs("hl_end", RUN, 1'b0, 2, 0);

        // Dropping the request in MEM_WAIT counts as completion.
        do_reset(idle);
        step("dr1", ms,   mk_ex(EN_NONE, 2'b00, RUN,      1'b0));
        step("dr2", idle, mk_ex(EN_ALL,  2'b00, MEM_WAIT, 1'b0));
        check_regs("dr_end", RUN, 1'b0, 1, 0);

        // Ready in the final allowed cycle beats the timeout.
        do_reset(idle);
        step("fr1", ms,  mk_ex(EN_NONE, 2'b00, RUN,      1'b0));
        step("fr2", ms,  mk_ex(EN_NONE, 2'b00, MEM_WAIT, 1'b0));
        step("fr3", ms,  mk_ex(EN_NONE, 2'b00, MEM_WAIT, 1'b0));
        step("fr4", rdy, mk_ex(EN_ALL,  2'b00, MEM_WAIT, 1'b0));
        check_regs("fr_end", RUN, 1'b0, 3, 0);

        // Timeout after four stalled cycles; HALT is left only by reset.
        do_reset(idle);
        step("to1", ms, mk_ex(EN_NONE, 2'b00, RUN,      1'b0));
        step("to2", ms, mk_ex(EN_NONE, 2'b00, MEM_WAIT, 1'b0));
        step("to3", ms, mk_ex(EN_NONE, 2'b00, MEM_WAIT, 1'b0));
        step("to4", ms, mk_ex(EN_NONE, 2'b00, MEM_WAIT, 1'b0));
        check_regs("to_halt", HALT, 1'b1, 4, 0);
        step("to5", rdy,  mk_ex(EN_NONE, 2'b00, HALT, 1'b1));
        step("to6", idle, mk_ex(EN_NONE, 2'b00, HALT, 1'b1));
        check_regs("to_hold", HALT, 1'b1, 6, 0);
        step("to7", br,   mk_ex(EN_NONE, 2'b00, HALT, 1'b1));
        step("to8", idle, mk_ex(EN_NONE, 2'b00, HALT, 1'b1));
        check_regs("to_sat", HALT, 1'b1, 7, 0);
        do_reset(idle);
        check_regs("to_rst", RUN, 1'b0, 0, 0);
        step("to9", idle, mk_ex(EN_ALL, 2'b00, RUN, 1'b0));

        // Reset in the middle of a memory wait.
        do_reset(idle);
        step("rm1", ms, mk_ex(EN_NONE, 2'b00, RUN,      1'b0));
        step("rm2", ms, mk_ex(EN_NONE, 2'b00, MEM_WAIT, 1'b0));
        do_reset(ms);
        check_regs("rm_rst", RUN, 1'b0, 0, 0);
        step("rm3", ms, mk_ex(EN_NONE, 2'b00, RUN, 1'b0));
        check_regs("rm_end", MEM_WAIT, 1'b0, 1, 0);

        // Counter saturation.
        do_reset(idle);
        for (int k = 0; k < 10; k++) step("sat_lu", lu, mk_ex(EN_LU, 2'b01, RUN, 1'b0));
        for (int k = 0; k < 9; k++)  step("sat_br", br, mk_ex(EN_ALL, 2'b11, RUN, 1'b0));
        check_regs("sat", RUN, 1'b0, 7, 7);

        // No counting while reset is held, even with hazards on the inputs.
        rst = 1'b1;
        drive(mk_in(5'd1, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0));
        repeat (2) begin
            @(negedge clk);
            check("rsth.en",  32'(en_vec),           32'(EN_ALL));
            check("rsth.clr", 32'({clr_de, clr_ex}), 32'(2'b11));
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        drive(idle);
        check_regs("rsth", RUN, 1'b0, 0, 0);

        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard: %0d entries left, expected 0", sb_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
